// File: rtl/uart_bus_master.sv
// UART debug bridge: parses 'W'/'R' byte commands, issues one native-bus transfer as
// initiator and streams the response bytes back to the UART transmitter.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES     = 65536
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [7:0] OpWrite     = 8'h57;
    localparam logic [7:0] OpRead      = 8'h52;
    localparam logic [7:0] RespOk      = 8'h4B;
    localparam logic [7:0] RespBad     = 8'h3F;
    localparam logic [7:0] RespTimeout = 8'h54;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_q;
    logic [31:0] gap_cnt;
    logic [31:0] tmo_cnt;
    logic [23:0] resp_sr;
    logic [1:0]  resp_left;

    assign mem_addr = {addr_q[31:2], 2'b00};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            addr_q    <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem_valid <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            resp_sr   <= '0;
            resp_left <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_valid) begin
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        if (rx_data == OpWrite || rx_data == OpRead) begin
                            is_write <= (rx_data == OpWrite);
                            state    <= ADDR;
                        end else begin
                            tx_data   <= RespBad;
                            tx_valid  <= 1'b1;
                            resp_left <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ADDR, DATA: begin
                    // A byte landing on the expiry cycle wins over the gap timeout.
                    if (rx_valid) begin
                        gap_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == ADDR) begin
                            addr_q <= {addr_q[23:0], rx_data};
                        end else begin
                            mem_wdata <= {mem_wdata[23:0], rx_data};
                        end
                        if (byte_cnt == 2'd3) begin
                            if (state == ADDR && is_write) begin
                                state <= DATA;
                            end else begin
                                state     <= BUS;
                                tmo_cnt   <= '0;
                                mem_wstrb <= is_write ? 4'hF : 4'h0;
                            end
                        end
                    end else if (gap_cnt == GAP_CYCLES - 1) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                BUS: begin
                    // Ready is checked before the timeout so a late completion still succeeds.
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        tx_valid  <= 1'b1;
                        state     <= RESP;
                        if (is_write) begin
                            tx_data   <= RespOk;
                            resp_left <= '0;
                        end else begin
                            tx_data   <= mem_rdata[31:24];
                            resp_sr   <= mem_rdata[23:0];
                            resp_left <= 2'd3;
                        end
                    end else if (tmo_cnt == TIMEOUT_CYCLES - 1) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        tx_data   <= RespTimeout;
                        tx_valid  <= 1'b1;
                        resp_left <= '0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (tx_valid && tx_ready) begin
                        if (resp_left == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data   <= resp_sr[23:16];
                            resp_sr   <= {resp_sr[15:0], 8'h00};
                            resp_left <= resp_left - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: table of commands plus hand-written timeout, gap and reset
// sequences; expected bus requests and tx bytes are queued and checked as the DUT emits them.
module tb_uart_bus_master;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned GAP     = 100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    uart_bus_master #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;      // write data for 'W', responder read data for 'R'
        int          lat;       // responder valid-to-ready latency
        int          gap;       // idle cycles between command bytes
        bit          stall;     // hold tx_ready low 5 cycles on second response byte
        bit          inject;    // push a stray byte while the bus request is pending
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
        int          lat;
    } bus_t;

    bus_t        bus_q[$];
    logic [7:0]  tx_q[$];
    int          checks = 0;
    int          errors = 0;

    int          lat = 1;
    bit          ready_en = 1'b1;
    logic [31:0] rdata_val = 32'h0;
    int          wait_cnt = 0;
    int          tx_count = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    int          valid_rises = 0;
    int          valid_run = 0;
    int          last_run = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr = 32'h0;
    logic [31:0] held_wdata = 32'h0;
    logic [3:0]  held_wstrb = 4'h0;
    bit          unstable = 1'b0;
    bus_t        b_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!mem_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_valid_seen"}, mem_valid, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || tx_q.size() != 0 || bus_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_done"}, {busy, tx_q.size() != 0, bus_q.size() != 0}, 3'b000);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int         r0;
        bit         is_w;
        bit         is_r;
        bus_t       be;
        logic [7:0] bytes[$];
        is_w      = (v.op == 8'h57);
        is_r      = (v.op == 8'h52);
        r0        = valid_rises;
        lat       = v.lat;
        rdata_val = v.data;
        if (is_w || is_r) begin
            be.addr      = v.exp_addr;
            be.wdata     = v.data;
            be.wstrb     = is_w ? 4'hF : 4'h0;
            be.chk_wdata = is_w;
            be.lat       = v.lat;
            bus_q.push_back(be);
        end
        if (is_w) tx_q.push_back(8'h4B);
        else if (is_r) for (int i = 3; i >= 0; i--) tx_q.push_back(v.data[8*i +: 8]);
        else tx_q.push_back(8'h3F);
        if (v.stall) begin
            stall_at   = tx_count + 1;
            stall_left = 5;
        end
        bytes.push_back(v.op);
        if (is_w || is_r) for (int i = 3; i >= 0; i--) bytes.push_back(v.addr[8*i +: 8]);
        if (is_w) for (int i = 3; i >= 0; i--) bytes.push_back(v.data[8*i +: 8]);
        foreach (bytes[i]) begin
            if (i > 0) idle(v.gap);
            send_byte(bytes[i]);
        end
        if (v.inject) begin
            wait_valid(name);
            send_byte(8'h57);
        end
        wait_done(name);
        chk({name, "_valid_rises"}, valid_rises - r0, (is_w || is_r) ? 1 : 0);
        if (v.stall) chk({name, "_stall_done"}, stall_left, 0);
    endtask

    // Responder, bus monitor and tx sink all act on the falling edge, away from the DUT edge.
    always @(negedge clk) begin
        if (!rstn) begin
            mem_ready  = 1'b0;
            wait_cnt   = 0;
            prev_valid = 1'b0;
            valid_run  = 0;
            tx_ready   = 1'b1;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_cnt  = 0;
            end else if (!mem_valid) begin
                wait_cnt = 0;
            end else if (ready_en) begin
                if (wait_cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_val;
                end else begin
                    wait_cnt++;
                end
            end

            if (mem_valid && !prev_valid) begin
                valid_rises++;
                valid_run  = 0;
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
                held_wstrb = mem_wstrb;
                unstable   = 1'b0;
            end
            if (mem_valid) begin
                valid_run++;
                if (mem_addr !== held_addr || mem_wdata !== held_wdata ||
                    mem_wstrb !== held_wstrb) unstable = 1'b1;
            end
            if (!mem_valid && prev_valid) last_run = valid_run;
            prev_valid = mem_valid;

            if (mem_valid && mem_ready) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got request at %h, want none", mem_addr);
                end else begin
                    b_pop = bus_q.pop_front();
                    chk("bus_addr", mem_addr, b_pop.addr);
                    chk("bus_wstrb", mem_wstrb, b_pop.wstrb);
                    if (b_pop.chk_wdata) chk("bus_wdata", mem_wdata, b_pop.wdata);
                    chk("bus_valid_cycles", valid_run, b_pop.lat + 1);
                    chk("bus_stable", unstable, 0);
                end
            end

            if (tx_valid && stall_left > 0 && tx_count == stall_at) begin
                tx_ready = 1'b0;
                stall_left--;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_hold: got %h, want nothing pending", tx_data);
                end else begin
                    chk("tx_hold", tx_data, tx_q[0]);
                end
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                tx_count++;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h, want none", tx_data);
                end else begin
                    chk("tx_byte", tx_data, tx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   r0;
        int   c0;
        vecs[0] = '{op: 8'h57, addr: 32'h10000004, data: 32'hDEADBEEF, lat: 1, gap: 0,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h10000004};
        vecs[1] = '{op: 8'h52, addr: 32'h90000003, data: 32'h000000A5, lat: 1, gap: 0,
                    stall: 1'b1, inject: 1'b0, exp_addr: 32'h90000000};
        vecs[2] = '{op: 8'h41, addr: 32'h0, data: 32'h0, lat: 1, gap: 0,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h0};
        vecs[3] = '{op: 8'h57, addr: 32'h20000007, data: 32'h12345678, lat: 3, gap: 0,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h20000004};
        vecs[4] = '{op: 8'h52, addr: 32'h00000000, data: 32'hCAFEF00D, lat: 2, gap: 2,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h00000000};
        vecs[5] = '{op: 8'h52, addr: 32'h30000010, data: 32'h80706050, lat: 4, gap: 0,
                    stall: 1'b0, inject: 1'b1, exp_addr: 32'h30000010};
        vecs[6] = '{op: 8'h57, addr: 32'h0000000A, data: 32'h0BADF00D, lat: 1, gap: GAP - 1,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h00000008};
        vecs[7] = '{op: 8'h00, addr: 32'h0, data: 32'h0, lat: 1, gap: 0,
                    stall: 1'b0, inject: 1'b0, exp_addr: 32'h0};

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_data", tx_data, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_mem_valid", mem_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_mem_wstrb", mem_wstrb, 0);
        chk("reset_busy", busy, 0);
        rstn = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Responder never answers: request abandoned after TIMEOUT cycles, 'T' only.
        ready_en = 1'b0;
        r0 = valid_rises;
        c0 = tx_count;
        tx_q.push_back(8'h54);
        send_byte(8'h52);
        send_word(32'h00000100);
        wait_done("timeout");
        chk("timeout_valid_cycles", last_run, TIMEOUT);
        chk("timeout_rises", valid_rises - r0, 1);
        chk("timeout_tx_count", tx_count - c0, 1);
        ready_en = 1'b1;

        // Partial write abandoned after GAP idle cycles; following read must run cleanly.
        r0 = valid_rises;
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        idle(GAP);
        chk("gap_expired_busy", busy, 0);
        run_vec('{op: 8'h52, addr: 32'h00000000, data: 32'h11223344, lat: 1, gap: 0,
                  stall: 1'b0, inject: 1'b0, exp_addr: 32'h00000000}, "gap_read");
        chk("gap_rises", valid_rises - r0, 1);

        // Reset while a write is on the bus.
        ready_en = 1'b0;
        c0 = tx_count;
        send_byte(8'h57);
        send_word(32'h00000010);
        send_word(32'h11111111);
        wait_valid("rst");
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        ready_en = 1'b1;
        idle(2);
        rstn = 1'b1;
        idle(20);
        chk("rst_no_response", tx_count - c0, 0);
        chk("rst_idle_busy", busy, 0);
        run_vec('{op: 8'h57, addr: 32'h40000020, data: 32'hA5A55A5A, lat: 1, gap: 0,
                  stall: 1'b0, inject: 1'b0, exp_addr: 32'h40000020}, "post_rst_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/loader bridge that drives the same native memory bus the CPU uses (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) as the initiator, not the responder.
- Accepts command bytes from a UART receiver and issues single-word bus reads and writes to ROM, RAM, UART or LED space.
- Returns the response bytes to a UART transmitter.
- Sits beside the CPU behind a bus arbiter; that arbiter is outside this block.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles mem_valid stays high without mem_ready before the transfer is abandoned.
- GAP_CYCLES, 65536: max idle cycles between bytes of one command before the partial command is discarded.

Ports:
- clk  in  1  system clock (25 MHz domain)
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  response byte
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completion pulse
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 for write, 4'b0000 for read
- mem_rdata  in  32  read data, valid when mem_ready=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: async on rstn low. All outputs go to 0: tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy. State goes to IDLE; counters clear.
- Command format (multi-byte fields big-endian, MSB first):
  - 'W' (0x57) + 4 addr bytes + 4 data bytes -> one write, response 'K' (0x4B).
  - 'R' (0x52) + 4 addr bytes -> one read, response 4 data bytes MSB first.
  - Any other first byte -> response '?' (0x3F), no bus access.
- States: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: on rx_valid, latch opcode.
    - 'W' or 'R' -> ADDR with byte counter = 0.
    - Otherwise load '?' -> RESP.
  - ADDR: each rx_valid shifts a byte into the addr register. After the 4th byte: 'W' -> DATA; 'R' -> BUS.
  - DATA: 4 bytes shifted into the wdata register, then -> BUS.
  - BUS:
    - mem_valid asserts on the cycle after entry, with addr, wdata and wstrb already stable. All hold unchanged until completion.
    - On the edge where mem_ready=1 is sampled, mem_valid deasserts. For a read, mem_rdata is captured on that same edge. -> RESP.
    - mem_valid is never high for two cycles after mem_ready is seen. Minimum valid-to-ready latency supported: 1 cycle (registered responder).
  - RESP: present the response bytes in order. Each byte is held on tx_data with tx_valid=1 until tx_ready. A new byte may present on the cycle after acceptance. After the last byte is accepted -> IDLE, tx_valid=0.
- Timeouts:
  - Bus timeout: cycle counter runs while mem_valid=1. When it reaches TIMEOUT_CYCLES, drop mem_valid, skip any data capture, respond 'T' (0x54) only, even for a read.
  - Gap timeout: in ADDR or DATA, counter resets on each rx_valid. When it reaches GAP_CYCLES, return to IDLE silently. Partial fields are discarded; no bus access, no response.
- Bytes arriving in BUS or RESP are dropped and not queued.
- Simultaneous events: a mem_ready on the same cycle the timeout is reached counts as success. An rx_valid on the same cycle the gap expires is accepted and the counter restarts.
- Address: mem_addr = {addr[31:2], 2'b00}. The low two received bits are ignored.
- Reset mid-transfer drops mem_valid immediately. No response is generated afterwards.

Test Plan:
- Write: send 57 10 00 00 04 DE AD BE EF; responder gives mem_ready 1 cycle after valid -> exactly one request: mem_addr=0x10000004, mem_wdata=0xDEADBEEF, mem_wstrb=4'hF, valid high 2 cycles; tx sends 0x4B.
- Read: send 52 90 00 00 03; responder returns mem_rdata=0x000000A5 -> mem_addr=0x90000000, mem_wstrb=0; tx sends 00 00 00 A5 in order. Hold tx_ready low 5 cycles on byte 2 -> tx_data stays stable at 0x00 throughout.
- Bus timeout: TIMEOUT_CYCLES=16, responder never asserts ready -> mem_valid drops after 16 cycles; tx sends 0x54 only; busy returns to 0.
- Gap timeout: GAP_CYCLES=100, send 57 10 00, then wait 100 idle cycles, then send 52 00 00 00 00 -> mem_valid never rises for the partial write; the read executes at addr 0x00000000.
- Bad opcode plus dropped bytes: send 0x41 -> tx sends 0x3F, no mem_valid. During a read's BUS state, inject rx byte 0x57 -> ignored; next command parses correctly.
- Reset: assert rstn low while mem_valid=1 -> mem_valid, tx_valid and busy go to 0 asynchronously; after release, state is IDLE and a fresh write completes normally.
